// File: rtl/text_overlay_ctrl.sv
// Game-state sequencer for the VGA text overlay: blinks the start prompt while idle,
// slides the GAME OVER banner down at game end, and hands start/clear to game logic.
module text_overlay_ctrl #(
    parameter int BLINK_FRAMES = 30,
    parameter int SLIDE_STEP   = 4,
    parameter int OVER_X       = 228,
    parameter int OVER_Y       = 230,
    parameter int PROMPT_X     = 155,
    parameter int PROMPT_Y     = 300,
    parameter int HOLD_FRAMES  = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       sw0,
    input  logic       game_over,
    output logic [7:0] text_type,
    output logic [9:0] display_x_start,
    output logic [9:0] display_y_start,
    output logic       text_enable,
    output logic       game_run,
    output logic       clear_req
);

    typedef enum logic [1:0] {IDLE, RUN, OVER_SLIDE, OVER_HOLD} state_t;

    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    state_t        state;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic [HW-1:0] hold_cnt;
    logic          sw0_d;
    logic          start_edge;
    logic [10:0]   y_next;

    assign start_edge = sw0 & ~sw0_d;
    // 11-bit sum so the clamp against OVER_Y can never be fooled by a 10-bit wrap
    assign y_next     = {1'b0, display_y_start} + 11'(SLIDE_STEP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            text_type       <= 8'd1;
            display_x_start <= 10'(PROMPT_X);
            display_y_start <= 10'(PROMPT_Y);
            text_enable     <= 1'b1;
            game_run        <= 1'b0;
            clear_req       <= 1'b0;
            blink_cnt       <= '0;
            blink_on        <= 1'b1;
            hold_cnt        <= '0;
            sw0_d           <= 1'b1;
        end else begin
            sw0_d <= sw0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state       <= RUN;
                        clear_req   <= 1'b1;
                        game_run    <= 1'b1;
                        text_enable <= 1'b0;
                    end else if (frame_tick) begin
                        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                            blink_cnt   <= '0;
                            blink_on    <= ~blink_on;
                            text_enable <= ~blink_on;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    clear_req <= 1'b0;
                    // game_over is stale on the entry cycle; game logic clears it off clear_req
                    if (!clear_req && game_over) begin
                        state           <= OVER_SLIDE;
                        game_run        <= 1'b0;
                        text_type       <= 8'd0;
                        display_x_start <= 10'(OVER_X);
                        display_y_start <= 10'd0;
                        text_enable     <= 1'b1;
                    end
                end
                OVER_SLIDE: begin
                    if (frame_tick) begin
                        if (y_next >= 11'(OVER_Y)) begin
                            display_y_start <= 10'(OVER_Y);
                            state           <= OVER_HOLD;
                            hold_cnt        <= '0;
                        end else begin
                            display_y_start <= y_next[9:0];
                        end
                    end
                end
                OVER_HOLD: begin
                    if (hold_cnt == HW'(HOLD_FRAMES) && !sw0) begin
                        state           <= IDLE;
                        text_type       <= 8'd1;
                        display_x_start <= 10'(PROMPT_X);
                        display_y_start <= 10'(PROMPT_Y);
                        text_enable     <= 1'b1;
                        blink_cnt       <= '0;
                        blink_on        <= 1'b1;
                    end else if (frame_tick && hold_cnt != HW'(HOLD_FRAMES)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Directed bench for text_overlay_ctrl: reset/start gating, prompt blink, banner slide,
// hold/restart and reset mid-slide, with hand-computed expectations.
module tb_text_overlay_ctrl;

    logic       clk = 1'b0;
    logic       reset, frame_tick, sw0, game_over;
    logic [7:0] text_type;
    logic [9:0] display_x_start, display_y_start;
    logic       text_enable, game_run, clear_req;

    int checks = 0;
    int errors = 0;

    text_overlay_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .sw0(sw0),
        .game_over(game_over), .text_type(text_type),
        .display_x_start(display_x_start), .display_y_start(display_y_start),
        .text_enable(text_enable), .game_run(game_run), .clear_req(clear_req)
    );

    always #5 clk = ~clk;

    // inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        int pulses = 0;
        reset = 1'b1; sw0 = 1'b1; frame_tick = 1'b0; game_over = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        checks++;
        if (text_type !== 8'd1 || display_x_start !== 10'd155 || display_y_start !== 10'd300) begin
            errors++;
            $display("FAIL reset_text: type=%0d x=%0d y=%0d want 1/155/300",
                     text_type, display_x_start, display_y_start);
        end
        checks++;
        if (text_enable !== 1'b1 || game_run !== 1'b0 || clear_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: en=%b run=%b clr=%b want 1/0/0", text_enable, game_run, clear_req);
        end
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (clear_req === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || game_run !== 1'b0) begin
            errors++;
            $display("FAIL sw0_high_thru_reset: pulses=%0d run=%b want 0/0", pulses, game_run);
        end
    endtask

    task automatic test_blink();
        int bad = 0;
        logic exp_en;
        sw0 = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            tick();
            exp_en = (k < 30) ? 1'b1 : (k < 60) ? 1'b0 : 1'b1;
            if (text_enable !== exp_en) bad++;
            if (text_type !== 8'd1 || display_x_start !== 10'd155 || display_y_start !== 10'd300) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL blink: %0d bad samples over 70 ticks, want 0", bad);
        end
    endtask

    // rising sw0 with a frame_tick in the same cycle, game_over already high
    task automatic test_start_and_over();
        int pulses = 0;
        game_over = 1'b1;
        sw0 = 1'b1; frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        pulses += (clear_req === 1'b1) ? 1 : 0;
        checks++;
        if (clear_req !== 1'b1 || game_run !== 1'b1 || text_enable !== 1'b0) begin
            errors++;
            $display("FAIL start: clr=%b run=%b en=%b want 1/1/0", clear_req, game_run, text_enable);
        end
        cyc();
        pulses += (clear_req === 1'b1) ? 1 : 0;
        checks++;
        if (game_run !== 1'b1 || text_type !== 8'd1) begin
            errors++;
            $display("FAIL over_ignored_on_entry: run=%b type=%0d want 1/1", game_run, text_type);
        end
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        pulses += (clear_req === 1'b1) ? 1 : 0;
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL clear_pulse: pulses=%0d want 1", pulses);
        end
        checks++;
        if (text_type !== 8'd0 || display_x_start !== 10'd228 || display_y_start !== 10'd0 ||
            game_run !== 1'b0 || text_enable !== 1'b1) begin
            errors++;
            $display("FAIL over_entry: type=%0d x=%0d y=%0d run=%b en=%b want 0/228/0/0/1",
                     text_type, display_x_start, display_y_start, game_run, text_enable);
        end
        game_over = 1'b0;
    endtask

    task automatic test_slide_hold();
        int bad = 0;
        for (int k = 1; k <= 57; k++) begin
            tick();
            if (display_y_start !== 10'(4 * k)) bad++;
        end
        checks++;
        if (bad !== 0 || display_y_start !== 10'd228) begin
            errors++;
            $display("FAIL slide: bad=%0d y=%0d want 0/228", bad, display_y_start);
        end
        tick();
        checks++;
        if (display_y_start !== 10'd230) begin
            errors++;
            $display("FAIL slide_clamp: y=%0d want 230", display_y_start);
        end
        repeat (59) tick();
        sw0 = 1'b0;
        cyc();
        checks++;
        if (text_type !== 8'd0 || display_y_start !== 10'd230) begin
            errors++;
            $display("FAIL hold_early_exit: type=%0d y=%0d want 0/230", text_type, display_y_start);
        end
        sw0 = 1'b1;
        repeat (6) tick();
        checks++;
        if (text_type !== 8'd0 || display_y_start !== 10'd230 || text_enable !== 1'b1 || game_run !== 1'b0) begin
            errors++;
            $display("FAIL hold_sw0_high: type=%0d y=%0d en=%b run=%b want 0/230/1/0",
                     text_type, display_y_start, text_enable, game_run);
        end
        sw0 = 1'b0;
        cyc();
        checks++;
        if (text_type !== 8'd1 || display_x_start !== 10'd155 || display_y_start !== 10'd300 ||
            text_enable !== 1'b1) begin
            errors++;
            $display("FAIL hold_exit: type=%0d x=%0d y=%0d en=%b want 1/155/300/1",
                     text_type, display_x_start, display_y_start, text_enable);
        end
        sw0 = 1'b1;
        cyc();
        checks++;
        if (clear_req !== 1'b1 || game_run !== 1'b1) begin
            errors++;
            $display("FAIL restart: clr=%b run=%b want 1/1", clear_req, game_run);
        end
    endtask

    task automatic test_reset_mid_slide();
        cyc();
        game_over = 1'b1;
        cyc();
        game_over = 1'b0;
        repeat (30) tick();
        checks++;
        if (display_y_start !== 10'd120) begin
            errors++;
            $display("FAIL mid_slide_y: y=%0d want 120", display_y_start);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if (text_type !== 8'd1 || display_y_start !== 10'd300 || game_run !== 1'b0 ||
            text_enable !== 1'b1 || clear_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_slide: type=%0d y=%0d run=%b en=%b clr=%b want 1/300/0/1/0",
                     text_type, display_y_start, game_run, text_enable, clear_req);
        end
        // sw0 still high after reset: must not start until seen low
        repeat (5) cyc();
        checks++;
        if (game_run !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_hold_off: run=%b want 0", game_run);
        end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_start_and_over();
        test_slide_hold();
        test_reset_mid_slide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
